// File: rtl/fcvt_fp_to_int.sv
// Multi-cycle FP-to-integer converter (FCVT.{W,WU,L,LU}.{S,D}).
// Aligns the unpacked significand with a stepped shifter, rounds, saturates and raises NV/NX.
module fcvt_fp_to_int #(
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        sign_i,
  input  logic [12:0] exp_i,
  input  logic [52:0] sig_i,
  input  logic [5:0]  class_i,
  input  logic        is64_i,
  input  logic        unsigned_i,
  input  logic [2:0]  rm_i,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [63:0] result_o,
  output logic        flagNV_o,
  output logic        flagNX_o
);

  // One-hot class bit positions.
  localparam int CLS_QNAN = 5;
  localparam int CLS_SNAN = 4;
  localparam int CLS_INF  = 3;
  localparam int CLS_ZERO = 2;

  localparam logic [6:0] STEP_W   = 7'(SHIFT_STEP);
  localparam logic [6:0] DIST_MAX = 7'd66;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SPECIAL = 3'd1,
    S_SHIFT   = 3'd2,
    S_ROUND   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic        is64_q, is64_d;
  logic        uns_q, uns_d;
  logic [2:0]  rm_q, rm_d;
  logic [63:0] int_q, int_d;
  logic        g_q, g_d;
  logic        s_q, s_d;
  logic [6:0]  dist_q, dist_d;
  logic        lsh_q, lsh_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [63:0] result_q, result_d;
  logic        nv_q, nv_d;
  logic        nx_q, nx_d;

  // Saturated result for an out-of-range magnitude of the given sign.
  function automatic logic [63:0] sat_value(input logic sgn, input logic w64, input logic uns);
    logic [63:0] v;
    if (uns) begin
      v = sgn ? 64'h0000_0000_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (w64) begin
      v = sgn ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    end else begin
      v = sgn ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_7FFF_FFFF;
    end
    return v;
  endfunction

  // Largest representable magnitude for the given sign and target format.
  function automatic logic [64:0] mag_limit(input logic sgn, input logic w64, input logic uns);
    logic [64:0] v;
    if (uns) begin
      if (sgn) begin
        v = 65'h0_0000_0000_0000_0000;
      end else begin
        v = w64 ? 65'h0_FFFF_FFFF_FFFF_FFFF : 65'h0_0000_0000_FFFF_FFFF;
      end
    end else begin
      if (sgn) begin
        v = w64 ? 65'h0_8000_0000_0000_0000 : 65'h0_0000_0000_8000_0000;
      end else begin
        v = w64 ? 65'h0_7FFF_FFFF_FFFF_FFFF : 65'h0_0000_0000_7FFF_FFFF;
      end
    end
    return v;
  endfunction

  logic               accept_s;
  logic               is_nan_s, is_inf_s, is_zero_s, exp_big_s, special_s;
  logic signed [13:0] dist_full_s;
  logic signed [13:0] lsh_amt_s;
  logic [6:0]         step_s;
  logic [127:0]       wide_s;
  logic               inc_s;
  logic [64:0]        mag_s;
  logic [63:0]        neg_s, val_s;

  // Operand classification, rounding and alignment helpers.
  always_comb begin
    accept_s    = valid_i & ready_q;
    is_nan_s    = class_i[CLS_QNAN] | class_i[CLS_SNAN];
    is_inf_s    = class_i[CLS_INF];
    is_zero_s   = class_i[CLS_ZERO];
    exp_big_s   = $signed(exp_i) > $signed(13'sd63);
    special_s   = is_nan_s | is_inf_s | is_zero_s | exp_big_s;
    dist_full_s = 14'sd52 - $signed({exp_i[12], exp_i});
    lsh_amt_s   = 14'sd0 - dist_full_s;

    step_s = (dist_q < STEP_W) ? dist_q : STEP_W;
    wide_s = {int_q, 64'd0} >> step_s;

    case (rm_q)
      3'b000:  inc_s = g_q & (s_q | int_q[0]);
      3'b001:  inc_s = 1'b0;
      3'b010:  inc_s = sign_q & (g_q | s_q);
      3'b011:  inc_s = ~sign_q & (g_q | s_q);
      3'b100:  inc_s = g_q;
      default: inc_s = g_q & (s_q | int_q[0]);
    endcase
    mag_s = {1'b0, int_q} + {64'd0, inc_s};
    neg_s = 64'd0 - mag_s[63:0];
    val_s = sign_q ? neg_s : mag_s[63:0];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    is64_d   = is64_q;
    uns_d    = uns_q;
    rm_d     = rm_q;
    int_d    = int_q;
    g_d      = g_q;
    s_d      = s_q;
    dist_d   = dist_q;
    lsh_d    = lsh_q;
    result_d = result_q;
    nv_d     = nv_q;
    nx_d     = nx_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          sign_d = sign_i;
          is64_d = is64_i;
          uns_d  = unsigned_i;
          rm_d   = rm_i;
          int_d  = {11'd0, sig_i};
          g_d    = 1'b0;
          s_d    = 1'b0;
          if (special_s) begin
            state_d = S_SPECIAL;
            nx_d    = 1'b0;
            if (is_nan_s) begin
              result_d = sat_value(1'b0, is64_i, unsigned_i);
              nv_d     = 1'b1;
            end else if (is_inf_s | exp_big_s) begin
              result_d = sat_value(sign_i, is64_i, unsigned_i);
              nv_d     = 1'b1;
            end else begin
              result_d = 64'd0;
              nv_d     = 1'b0;
            end
          end else begin
            state_d = S_SHIFT;
            if (dist_full_s <= 14'sd0) begin
              lsh_d  = 1'b1;
              dist_d = {3'd0, lsh_amt_s[3:0]};
            end else if (dist_full_s > 14'sd66) begin
              lsh_d  = 1'b0;
              dist_d = DIST_MAX;
            end else begin
              lsh_d  = 1'b0;
              dist_d = dist_full_s[6:0];
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SPECIAL: begin
        state_d = ready_i ? S_IDLE : S_DONE;
      end
      S_SHIFT: begin
        if (lsh_q) begin
          int_d   = int_q << dist_q[3:0];
          state_d = S_ROUND;
        end else begin
          int_d  = wide_s[127:64];
          g_d    = wide_s[63];
          s_d    = (|wide_s[62:0]) | g_q | s_q;
          dist_d = dist_q - step_s;
          if (dist_q <= STEP_W) begin
            state_d = S_ROUND;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (mag_s > mag_limit(sign_q, is64_q, uns_q)) begin
          result_d = sat_value(sign_q, is64_q, uns_q);
          nv_d     = 1'b1;
          nx_d     = 1'b0;
        end else begin
          result_d = is64_q ? val_s : {{32{val_s[31]}}, val_s[31:0]};
          nv_d     = 1'b0;
          nx_d     = g_q | s_q;
        end
      end
      S_DONE: begin
        state_d = ready_i ? S_IDLE : S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    valid_d = (state_d == S_SPECIAL) || (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      is64_q   <= 1'b0;
      uns_q    <= 1'b0;
      rm_q     <= 3'd0;
      int_q    <= 64'd0;
      g_q      <= 1'b0;
      s_q      <= 1'b0;
      dist_q   <= 7'd0;
      lsh_q    <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= 64'd0;
      nv_q     <= 1'b0;
      nx_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      is64_q   <= is64_d;
      uns_q    <= uns_d;
      rm_q     <= rm_d;
      int_q    <= int_d;
      g_q      <= g_d;
      s_q      <= s_d;
      dist_q   <= dist_d;
      lsh_q    <= lsh_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      nv_q     <= nv_d;
      nx_q     <= nx_d;
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign flagNV_o = nv_q;
  assign flagNX_o = nx_q;

endmodule

// File: tb/tb_fcvt_fp_to_int.sv
// Directed self-checking bench for fcvt_fp_to_int (SHIFT_STEP = 8).
module tb_fcvt_fp_to_int;

  localparam logic [5:0] C_QNAN = 6'b100000;
  localparam logic [5:0] C_SNAN = 6'b010000;
  localparam logic [5:0] C_INF  = 6'b001000;
  localparam logic [5:0] C_ZERO = 6'b000100;
  localparam logic [5:0] C_NORM = 6'b000001;

  localparam logic [52:0] SIG_1P0  = 53'h10000000000000;
  localparam logic [52:0] SIG_1P5  = 53'h18000000000000;
  localparam logic [52:0] SIG_1P25 = 53'h14000000000000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        sign_i = 1'b0;
  logic [12:0] exp_i = 13'd0;
  logic [52:0] sig_i = 53'd0;
  logic [5:0]  class_i = 6'd0;
  logic        is64_i = 1'b0;
  logic        unsigned_i = 1'b0;
  logic [2:0]  rm_i = 3'd0;
  logic        ready_o, valid_o;
  logic        ready_i = 1'b0;
  logic [63:0] result_o;
  logic        flagNV_o, flagNX_o;

  int checks = 0;
  int errors = 0;

  fcvt_fp_to_int #(.SHIFT_STEP(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .sign_i(sign_i), .exp_i(exp_i),
    .sig_i(sig_i), .class_i(class_i), .is64_i(is64_i), .unsigned_i(unsigned_i), .rm_i(rm_i),
    .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .flagNV_o(flagNV_o), .flagNX_o(flagNX_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic s, input logic [12:0] e, input logic [52:0] sg,
                       input logic [5:0] c, input logic w64, input logic u, input logic [2:0] r);
    valid_i = 1'b1; sign_i = s; exp_i = e; sig_i = sg; class_i = c;
    is64_i = w64; unsigned_i = u; rm_i = r;
    @(posedge clk); #1;
    // Scramble operands after accept to show they are captured.
    valid_i = 1'b0; sign_i = ~s; exp_i = ~e; sig_i = ~sg; class_i = C_NORM;
    is64_i = ~w64; unsigned_i = ~u; rm_i = r ^ 3'b001;
  endtask

  task automatic run_op(input string tag, input logic s, input logic [12:0] e, input logic [52:0] sg,
                        input logic [5:0] c, input logic w64, input logic u, input logic [2:0] r,
                        input logic [63:0] x_res, input logic x_nv, input logic x_nx,
                        input int x_lat, input int hold);
    int cyc;
    cyc = 0;
    while (!ready_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    drive(s, e, sg, c, w64, u, r);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!valid_o && cyc < 200);
    chk({tag, " valid"}, {63'd0, valid_o}, 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(x_lat));
    for (int i = 0; i < hold; i++) begin
      chk({tag, " hold ready"}, {63'd0, ready_o}, 64'd0);
      chk({tag, " hold result"}, result_o, x_res);
      @(negedge clk);
      chk({tag, " hold valid"}, {63'd0, valid_o}, 64'd1);
    end
    chk({tag, " result"}, result_o, x_res);
    chk({tag, " NV"}, {63'd0, flagNV_o}, {63'd0, x_nv});
    chk({tag, " NX"}, {63'd0, flagNX_o}, {63'd0, x_nx});
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    @(negedge clk);
    chk({tag, " valid drop"}, {63'd0, valid_o}, 64'd0);
    chk({tag, " ready back"}, {63'd0, ready_o}, 64'd1);
  endtask

  initial begin
    int seen;
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst ready", {63'd0, ready_o}, 64'd0);
    chk("rst valid", {63'd0, valid_o}, 64'd0);
    chk("rst result", result_o, 64'd0);
    chk("rst flags", {62'd0, flagNV_o, flagNX_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("post-rst ready", {63'd0, ready_o}, 64'd1);

    // Rounding of 1.5 / -2.5 in W
    run_op("1.5 W RNE", 1'b0, 13'd0, SIG_1P5, C_NORM, 1'b0, 1'b0, 3'b000, 64'h2, 1'b0, 1'b1, 9, 0);
    run_op("1.5 W RTZ", 1'b0, 13'd0, SIG_1P5, C_NORM, 1'b0, 1'b0, 3'b001, 64'h1, 1'b0, 1'b1, 9, 0);
    run_op("-2.5 W RNE", 1'b1, 13'd1, SIG_1P25, C_NORM, 1'b0, 1'b0, 3'b000,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 9, 0);
    run_op("-2.5 W RMM", 1'b1, 13'd1, SIG_1P25, C_NORM, 1'b0, 1'b0, 3'b100,
           64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1, 9, 0);
    run_op("-1.5 W RDN", 1'b1, 13'd0, SIG_1P5, C_NORM, 1'b0, 1'b0, 3'b010,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 9, 0);
    run_op("2.5 W rm101", 1'b0, 13'd1, SIG_1P25, C_NORM, 1'b0, 1'b0, 3'b101, 64'h2, 1'b0, 1'b1, 9, 0);
    run_op("1.5 LU RUP", 1'b0, 13'd0, SIG_1P5, C_NORM, 1'b1, 1'b1, 3'b011, 64'h2, 1'b0, 1'b1, 9, 0);

    // W limits, including the round-up carry into overflow
    run_op("+2^31 W", 1'b0, 13'd31, SIG_1P0, C_NORM, 1'b0, 1'b0, 3'b000,
           64'h0000_0000_7FFF_FFFF, 1'b1, 1'b0, 5, 0);
    run_op("-2^31 W hold", 1'b1, 13'd31, SIG_1P0, C_NORM, 1'b0, 1'b0, 3'b000,
           64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 5, 5);
    run_op("2^31-0.5 W RNE", 1'b0, 13'd30, 53'h1FFFFFFFE00000, C_NORM, 1'b0, 1'b0, 3'b000,
           64'h0000_0000_7FFF_FFFF, 1'b1, 1'b0, 5, 0);

    // Special operands
    run_op("qNaN L", 1'b1, 13'd0, SIG_1P5, C_QNAN, 1'b1, 1'b0, 3'b000,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1, 0);
    run_op("sNaN WU", 1'b0, 13'd0, SIG_1P5, C_SNAN, 1'b0, 1'b1, 3'b000,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1, 0);
    run_op("-INF WU", 1'b1, 13'd0, SIG_1P0, C_INF, 1'b0, 1'b1, 3'b000, 64'h0, 1'b1, 1'b0, 1, 0);
    run_op("+INF WU", 1'b0, 13'd0, SIG_1P0, C_INF, 1'b0, 1'b1, 3'b000,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1, 0);
    run_op("exp64 L", 1'b0, 13'd64, SIG_1P0, C_NORM, 1'b1, 1'b0, 3'b000,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1, 0);
    run_op("zero L", 1'b1, 13'd0, 53'd0, C_ZERO, 1'b1, 1'b0, 3'b011, 64'h0, 1'b0, 1'b0, 1, 0);

    // Unsigned with negative operands
    run_op("-0.5 WU RTZ", 1'b1, 13'h1FFF, SIG_1P0, C_NORM, 1'b0, 1'b1, 3'b001, 64'h0, 1'b0, 1'b1, 9, 0);
    run_op("-1.0 WU", 1'b1, 13'd0, SIG_1P0, C_NORM, 1'b0, 1'b1, 3'b000, 64'h0, 1'b1, 1'b0, 9, 0);

    // Tiny magnitude (distance clamped) and left-shift path
    run_op("2^-200 L RUP", 1'b0, 13'h1F38, SIG_1P0, C_NORM, 1'b1, 1'b0, 3'b011, 64'h1, 1'b0, 1'b1, 11, 0);
    run_op("2^-200 L RNE", 1'b0, 13'h1F38, SIG_1P0, C_NORM, 1'b1, 1'b0, 3'b000, 64'h0, 1'b0, 1'b1, 11, 0);
    run_op("2^60 L", 1'b0, 13'd60, SIG_1P0, C_NORM, 1'b1, 1'b0, 3'b000,
           64'h1000_0000_0000_0000, 1'b0, 1'b0, 3, 0);
    run_op("-2^63 L", 1'b1, 13'd63, SIG_1P0, C_NORM, 1'b1, 1'b0, 3'b000,
           64'h8000_0000_0000_0000, 1'b0, 1'b0, 3, 0);

    // Reset in the middle of SHIFT abandons the operation
    @(negedge clk);
    drive(1'b0, 13'h1F38, SIG_1P0, C_NORM, 1'b1, 1'b0, 3'b011);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst ready", {63'd0, ready_o}, 64'd0);
    chk("midrst valid", {63'd0, valid_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("midrst ready next", {63'd0, ready_o}, 64'd1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    chk("midrst no valid", 64'(seen), 64'd0);
    run_op("after rst 1.5 W", 1'b0, 13'd0, SIG_1P5, C_NORM, 1'b0, 1'b0, 3'b000, 64'h2, 1'b0, 1'b1, 9, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
